// File: rtl/chnlnk_word_fmt.sv
// rtl/chnlnk_word_fmt.sv - channel-link word formatter: header/data/CRC/trailer framing with sequence tracking
module chnlnk_word_fmt #(
  parameter logic [15:0] IDLE_WRD = 16'hBC50,
  parameter logic [15:0] TRL_WRD  = 16'hE0E0
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        VALID,
  input  logic        HDR,
  input  logic        RD,
  input  logic        LAST_WRD,
  input  logic        CLR_CRC,
  input  logic [6:0]  SEQ,
  input  logic [15:0] FIFO_DATA,
  input  logic [23:0] L1A_NUM,
  input  logic        L1A_PHS,
  input  logic [6:0]  SAMP_MAX,
  output logic [15:0] DOUT,
  output logic        DOUT_K,
  output logic        DOUT_VLD,
  output logic        FRM_DONE,
  output logic        SEQ_ERR,
  output logic [15:0] FRM_CNT
);

  typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_TAIL, ST_WAIT_SMP} state_t;

  state_t      r_state, w_next;
  logic        r_s1_valid, r_s1_hdr, r_s1_last;
  logic [6:0]  r_s1_seq;
  logic [23:0] r_l1a_num;
  logic        r_l1a_phs;
  logic [6:0]  r_samp_max;
  logic [15:0] r_crc;
  logic [6:0]  r_smp_idx, r_prev_seq, r_prev_hdr;
  logic        r_first_dat;
  logic [15:0] r_dout, r_frm_cnt;
  logic        r_dout_k, r_dout_vld, r_frm_done, r_seq_err;
  logic        w_hdr_wrd, w_dat_wrd, w_hdr0, w_crc_upd;
  logic        w_dat_err, w_hdr_err;
  logic [15:0] w_word;
  logic        w_unused_rd;

  // FIFO data already lines up with the registered strobes, so the read strobe itself is not needed
  assign w_unused_rd = RD;

  // MSB-first CRC-16 (x^16+x^12+x^5+1) over one 16-bit word
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] v;
    logic        fb;
    v = c;
    for (int i = 15; i >= 0; i--) begin
      fb = v[15] ^ d[i];
      v  = {v[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return v;
  endfunction

  assign w_hdr_wrd = r_s1_valid & r_s1_hdr;
  assign w_dat_wrd = r_s1_valid & ~r_s1_hdr;
  assign w_hdr0    = w_hdr_wrd & (r_s1_seq == 7'd0);
  assign w_crc_upd = w_dat_wrd & (r_s1_seq <= 7'd95);

  // stage 1: delay the frame strobes one cycle to meet the FIFO read data
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_s1_valid <= 1'b0;
      r_s1_hdr   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_seq   <= 7'd0;
    end else begin
      r_s1_valid <= VALID;
      r_s1_hdr   <= HDR;
      r_s1_last  <= LAST_WRD;
      r_s1_seq   <= SEQ;
    end
  end

  // select the outgoing word for the stage-1 slot
  always_comb begin
    w_word = IDLE_WRD;
    if (w_hdr_wrd) begin
      case (r_s1_seq)
        7'd0:    w_word = {4'hA, L1A_NUM[23:12]};
        7'd1:    w_word = {4'hB, r_l1a_num[11:0]};
        7'd2:    w_word = {4'hC, r_l1a_phs, r_samp_max, 4'h0};
        7'd3:    w_word = 16'hD000 | {9'd0, r_smp_idx};
        default: w_word = TRL_WRD;
      endcase
    end else if (w_dat_wrd) begin
      if (r_s1_seq <= 7'd95)       w_word = FIFO_DATA;
      else if (r_s1_seq == 7'd96)  w_word = r_crc;
      else if (r_s1_seq == 7'd97)  w_word = {2'b00, r_smp_idx, 7'h00};
      else                         w_word = TRL_WRD;
    end
  end

  // sequence continuity: data SEQ must step by one (a block may restart at 0 after its trailer)
  always_comb begin
    w_dat_err = 1'b0;
    w_hdr_err = 1'b0;
    if (w_dat_wrd) begin
      if (r_first_dat)
        w_dat_err = (r_s1_seq != 7'd0);
      else
        w_dat_err = !((r_s1_seq == r_prev_seq + 7'd1) ||
                      ((r_s1_seq == 7'd0) && (r_prev_seq >= 7'd98)));
    end
    if (w_hdr_wrd) begin
      case (r_state)
        ST_IDLE:   w_hdr_err = (r_s1_seq != 7'd0);
        ST_HEADER: w_hdr_err = (r_s1_seq != r_prev_hdr + 7'd1);
        default:   w_hdr_err = 1'b1;
      endcase
    end
  end

  // tracking state machine; an end-of-event word always returns to idle
  always_comb begin
    w_next = r_state;
    if (r_s1_last) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (w_hdr_wrd) w_next = ST_HEADER;
        ST_HEADER:   if (w_dat_wrd) w_next = ST_DATA;
        ST_DATA:     if (w_dat_wrd && (r_s1_seq == 7'd96)) w_next = ST_TAIL;
        ST_TAIL:     if (w_dat_wrd && (r_s1_seq == 7'd98)) w_next = ST_WAIT_SMP;
        ST_WAIT_SMP: if (r_s1_valid) w_next = ST_DATA;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // event header capture, sample index and previous-SEQ bookkeeping
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_l1a_num   <= 24'd0;
      r_l1a_phs   <= 1'b0;
      r_samp_max  <= 7'd0;
      r_smp_idx   <= 7'd0;
      r_prev_seq  <= 7'h7F;
      r_prev_hdr  <= 7'd0;
      r_first_dat <= 1'b0;
    end else begin
      if (w_hdr0) begin
        r_l1a_num   <= L1A_NUM;
        r_l1a_phs   <= L1A_PHS;
        r_samp_max  <= SAMP_MAX;
        r_smp_idx   <= 7'd0;
        r_first_dat <= 1'b1;
      end else if (w_dat_wrd && (r_s1_seq == 7'd98)) begin
        r_smp_idx <= r_smp_idx + 7'd1;
      end
      if (w_hdr_wrd) r_prev_hdr <= r_s1_seq;
      if (w_dat_wrd) begin
        r_prev_seq  <= r_s1_seq;
        r_first_dat <= 1'b0;
      end
    end
  end

  // running CRC over data words; a preset request overrides a same-cycle update
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)         r_crc <= 16'hFFFF;
    else if (CLR_CRC)   r_crc <= 16'hFFFF;
    else if (w_crc_upd) r_crc <= crc16_upd(r_crc, FIFO_DATA);
  end

  // stage 2: registered link word, event-done pulse, event counter and sticky error
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_dout     <= IDLE_WRD;
      r_dout_k   <= 1'b1;
      r_dout_vld <= 1'b0;
      r_frm_done <= 1'b0;
      r_frm_cnt  <= 16'd0;
      r_seq_err  <= 1'b0;
    end else begin
      r_dout     <= w_word;
      r_dout_k   <= ~r_s1_valid;
      r_dout_vld <= r_s1_valid;
      r_frm_done <= r_s1_last;
      if (r_s1_last) r_frm_cnt <= r_frm_cnt + 16'd1;
      if (w_dat_err || w_hdr_err) r_seq_err <= 1'b1;
    end
  end

  assign DOUT     = r_dout;
  assign DOUT_K   = r_dout_k;
  assign DOUT_VLD = r_dout_vld;
  assign FRM_DONE = r_frm_done;
  assign SEQ_ERR  = r_seq_err;
  assign FRM_CNT  = r_frm_cnt;

endmodule

// File: tb/tb_chnlnk_word_fmt.sv
// tb/tb_chnlnk_word_fmt.sv - self-checking bench for chnlnk_word_fmt
module tb_chnlnk_word_fmt;

  localparam logic [15:0] IDLE = 16'hBC50;
  localparam logic [15:0] TRL  = 16'hE0E0;

  logic        CLK, RST_B, VALID, HDR, RD, LAST_WRD, CLR_CRC, L1A_PHS;
  logic [6:0]  SEQ, SAMP_MAX;
  logic [15:0] FIFO_DATA;
  logic [23:0] L1A_NUM;
  logic [15:0] DOUT, FRM_CNT;
  logic        DOUT_K, DOUT_VLD, FRM_DONE, SEQ_ERR;

  chnlnk_word_fmt #(.IDLE_WRD(IDLE), .TRL_WRD(TRL)) dut (
    .CLK(CLK), .RST_B(RST_B), .VALID(VALID), .HDR(HDR), .RD(RD),
    .LAST_WRD(LAST_WRD), .CLR_CRC(CLR_CRC), .SEQ(SEQ), .FIFO_DATA(FIFO_DATA),
    .L1A_NUM(L1A_NUM), .L1A_PHS(L1A_PHS), .SAMP_MAX(SAMP_MAX),
    .DOUT(DOUT), .DOUT_K(DOUT_K), .DOUT_VLD(DOUT_VLD),
    .FRM_DONE(FRM_DONE), .SEQ_ERR(SEQ_ERR), .FRM_CNT(FRM_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] dout;
    logic        k;
    logic        vld;
    logic        done;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [6:0]  seq;
    logic [15:0] dout;
  } hvec_t;

  exp_t        exp_q[$];
  logic [15:0] m_crc, m_prev_data, pend_data;
  logic        m_prev_dat, m_err;
  logic [6:0]  m_idx;
  logic [15:0] m_cnt;
  int          n_checks, n_fail;

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    repeat (16) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_idle();
    exp_t e;
    e.dout = IDLE; e.k = 1'b1; e.vld = 1'b0; e.done = 1'b0; e.err = m_err; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // one input cycle; compares the word driven two cycles earlier and queues this one
  task automatic step_x(input logic v, input logic h, input logic [6:0] s, input logic l,
                        input logic c, input logic [15:0] d, input logic ovr, input logic [15:0] ovr_dout);
    exp_t e;
    @(negedge CLK);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk("dout", {16'd0, DOUT}, {16'd0, e.dout});
      chk("dout_k", {31'd0, DOUT_K}, {31'd0, e.k});
      chk("dout_vld", {31'd0, DOUT_VLD}, {31'd0, e.vld});
      chk("frm_done", {31'd0, FRM_DONE}, {31'd0, e.done});
      chk("seq_err", {31'd0, SEQ_ERR}, {31'd0, e.err});
      chk("frm_cnt", {16'd0, FRM_CNT}, {16'd0, e.cnt});
    end
    if (c) m_crc = 16'hFFFF;
    else if (m_prev_dat) m_crc = ref_crc(m_crc, m_prev_data);
    VALID = v; HDR = h; SEQ = s; LAST_WRD = l; CLR_CRC = c; RD = v & ~h;
    FIFO_DATA = pend_data;
    pend_data = d;
    e.k = ~v; e.vld = v;
    if (!v) e.dout = IDLE;
    else if (h) begin
      case (s)
        7'd0:    e.dout = {4'hA, L1A_NUM[23:12]};
        7'd1:    e.dout = {4'hB, L1A_NUM[11:0]};
        7'd2:    e.dout = {4'hC, L1A_PHS, SAMP_MAX, 4'h0};
        default: e.dout = {4'hD, 5'd0, m_idx};
      endcase
    end else if (s <= 7'd95) e.dout = d;
    else if (s == 7'd96) e.dout = m_crc;
    else if (s == 7'd97) e.dout = {2'b00, m_idx, 7'h00};
    else e.dout = TRL;
    if (ovr) e.dout = ovr_dout;
    if (v && h && s == 7'd0) m_idx = 7'd0;
    if (v && !h && s == 7'd98) m_idx = m_idx + 7'd1;
    if (l) m_cnt = m_cnt + 16'd1;
    e.done = l; e.err = m_err; e.cnt = m_cnt;
    exp_q.push_back(e);
    m_prev_dat  = v && !h && (s <= 7'd95);
    m_prev_data = d;
  endtask

  task automatic step(input logic v, input logic h, input logic [6:0] s, input logic l,
                      input logic c, input logic [15:0] d);
    step_x(v, h, s, l, c, d, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST_B = 1'b0;
    VALID = 0; HDR = 0; RD = 0; LAST_WRD = 0; CLR_CRC = 0; SEQ = 0; FIFO_DATA = 0;
    #1;
    chk("rst_dout", {16'd0, DOUT}, {16'd0, IDLE});
    chk("rst_dout_k", {31'd0, DOUT_K}, 32'd1);
    chk("rst_dout_vld", {31'd0, DOUT_VLD}, 32'd0);
    chk("rst_frm_done", {31'd0, FRM_DONE}, 32'd0);
    chk("rst_seq_err", {31'd0, SEQ_ERR}, 32'd0);
    chk("rst_frm_cnt", {16'd0, FRM_CNT}, 32'd0);
    m_crc = 16'hFFFF; m_idx = 7'd0; m_cnt = 16'd0; m_err = 1'b0;
    m_prev_dat = 1'b0; m_prev_data = 16'd0; pend_data = 16'd0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST_B = 1'b1;
    push_idle();
    push_idle();
  endtask

  // data blocks of 100 words; optional skipped SEQ, extra CRC preset, early abort
  task automatic run_blocks(input int nblk, input int skip_seq, input int clr_seq, input int abort_seq);
    logic c, l;
    for (int b = 0; b < nblk; b++) begin
      for (int s = 0; s < 100; s++) begin
        if (b == 0 && s == skip_seq) continue;
        if (b == 0 && skip_seq >= 0 && s == skip_seq + 1) m_err = 1'b1;
        c = (s == 0) || (b == 0 && clr_seq >= 0 && s == clr_seq + 1);
        l = (b == nblk - 1) && (s == 99);
        step(1'b1, 1'b0, 7'(s), l, c, 16'($urandom));
        if (b == 0 && s == abort_seq) return;
      end
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_event(input logic [23:0] l1a, input logic phs, input logic [6:0] smax,
                           input int skip_seq, input int clr_seq, input int abort_seq);
    L1A_NUM = l1a; L1A_PHS = phs; SAMP_MAX = smax;
    for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 7'(s), 1'b0, 1'b0, 16'($urandom));
    run_blocks(int'(smax) + 1, skip_seq, clr_seq, abort_seq);
  endtask

  hvec_t htab[4];

  initial begin
    n_checks = 0; n_fail = 0;
    RST_B = 1'b0; VALID = 0; HDR = 0; RD = 0; LAST_WRD = 0; CLR_CRC = 0;
    SEQ = 0; FIFO_DATA = 0; L1A_NUM = 0; L1A_PHS = 0; SAMP_MAX = 0;
    m_crc = 16'hFFFF; m_idx = 0; m_cnt = 0; m_err = 0; m_prev_dat = 0; m_prev_data = 0; pend_data = 0;

    do_reset();
    repeat (6) step(0, 0, 0, 0, 0, 0);

    htab[0] = '{7'd0, 16'hA123};
    htab[1] = '{7'd1, 16'hB456};
    htab[2] = '{7'd2, 16'hC020};
    htab[3] = '{7'd3, 16'hD000};
    L1A_NUM = 24'h123456; L1A_PHS = 1'b0; SAMP_MAX = 7'd2;
    for (int i = 0; i < 4; i++) step_x(1'b1, 1'b1, htab[i].seq, 1'b0, 1'b0, 16'h0, 1'b1, htab[i].dout);
    run_blocks(3, -1, -1, -1);
    chk("ev1_frm_cnt", {16'd0, FRM_CNT}, 32'd1);

    run_event(24'hABCDEF, 1'b1, 7'd1, -1, -1, -1);
    chk("ev2_frm_cnt", {16'd0, FRM_CNT}, 32'd2);
    chk("ev2_seq_err", {31'd0, SEQ_ERR}, 32'd0);

    run_event(24'h000777, 1'b0, 7'd0, 40, -1, -1);
    run_event(24'h5A5A5A, 1'b1, 7'd1, -1, -1, -1);
    chk("gap_sticky", {31'd0, SEQ_ERR}, 32'd1);

    run_event(24'h0F0F0F, 1'b0, 7'd0, -1, 10, -1);

    run_event(24'h314159, 1'b0, 7'd1, -1, -1, 50);
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);
    run_event(24'h271828, 1'b1, 7'd1, -1, -1, -1);
    chk("post_rst_frm_cnt", {16'd0, FRM_CNT}, 32'd1);

    for (int i = 0; i < 65534; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("frm_cnt_ffff", {16'd0, FRM_CNT}, 32'h0000FFFF);
    run_event(24'h999999, 1'b0, 7'd0, -1, -1, -1);
    chk("frm_cnt_wrap", {16'd0, FRM_CNT}, 32'd0);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
